// File: rtl/mult_if.sv
// Handshake and data bundle between the control unit and the sequential multiplier.
interface mult_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             mult_busy;
    logic             mult_done;

    modport master (
        output mult_start, a, b,
        input  hi, lo, mult_busy, mult_done
    );

    modport slave (
        input  mult_start, a, b,
        output hi, lo, mult_busy, mult_done
    );
endinterface

// File: rtl/mult.sv
// Sequential signed multiplier: radix-2 Booth, one step per clock.
// Product is delivered on hi/lo with a one-cycle mult_done pulse.
module mult #(
    parameter int unsigned WIDTH = 32
) (
    input logic   clk,
    input logic   reset,
    mult_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH:0]  m_q, m_d;
    logic [WIDTH:0]  acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic            q1_q, q1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Set after the last Booth step; the following RUN cycle moves the product out.
    logic            fin_q, fin_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic [WIDTH:0]  acc_sum;

    // Booth add/subtract selected by {Q[0], Q_1}.
    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   acc_sum = acc_q + m_q;
            2'b10:   acc_sum = acc_q - m_q;
            default: acc_sum = acc_q;
        endcase
    end

    // Next-state logic for the control FSM and datapath.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.mult_start) begin
                    m_d     = {bus.a[WIDTH-1], bus.a};
                    acc_d   = '0;
                    q_d     = bus.b;
                    q1_d    = 1'b0;
                    cnt_d   = CntW'(WIDTH - 1);
                    fin_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fin_q) begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = q_q;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    // Arithmetic shift right of {A, Q, Q_1}.
                    acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
                    q_d   = {acc_sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    if (cnt_q == '0) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.hi        = hi_q;
        bus.lo        = lo_q;
        bus.mult_done = done_q;
        bus.mult_busy = (state_q != StIdle);
    end
endmodule
